// File: rtl/spi_ctrl_pkg.sv
// Shared constants for the SPI register-bus sequencer: state encoding,
// header bit layout and the response byte used after a bus timeout.
package spi_ctrl_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_WAIT = 3'd1;
    localparam logic [2:0] WR_BUS  = 3'd2;
    localparam logic [2:0] RD_BUS  = 3'd3;
    localparam logic [2:0] RD_WAIT = 3'd4;

    localparam int         HDR_RW_BIT   = 7;
    localparam logic [7:0] RESP_TIMEOUT = 8'hFF;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Register-bus handshake between the SPI sequencer (master) and the
// on-chip register block (slave).
interface spi_reg_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_wdata;
    logic              bus_ack;
    logic [7:0]        bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 1 so an
// idle (deasserted, active-low) chip select is seen during reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    // Shift the async input through two flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI transaction sequencer: turns received bytes into register-bus reads
// and writes, supplies the byte shifted out on the next SPI byte, and flags
// bus timeouts and bytes that arrive while an access is still outstanding.
module spi_reg_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int         ADDR_W      = 7,
    parameter int         ACK_TIMEOUT = 15,
    parameter logic [7:0] IDLE_RESP   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ssel,
    input  logic [7:0]            cmd,
    input  logic                  cmd_valid,
    output logic [7:0]            response,
    output logic                  err_timeout,
    output logic                  err_overrun,
    input  logic                  err_clr,
    spi_reg_ctrl_if.master        bus
);
    localparam int              CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic [2:0]        r_state;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic [7:0]        r_resp;
    logic [CNT_W-1:0]  r_tcnt;
    logic              r_err_to;
    logic              r_err_ov;

    logic w_ssel_s;
    logic w_done;
    logic w_tout;
    logic w_ovr;

    sync_2ff u_ssel_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (ssel),
        .o_q   (w_ssel_s)
    );

    // An ack on the terminal count cycle completes normally, so the timeout
    // only fires when no ack is present.
    assign w_done = r_req && bus.bus_ack && !w_ssel_s;
    assign w_tout = r_req && !bus.bus_ack && (r_tcnt == CNT_LAST) && !w_ssel_s;
    assign w_ovr  = cmd_valid && !w_ssel_s && ((r_state == WR_BUS) || (r_state == RD_BUS));

    // Main sequencer: state, bus request, address counter, timeout counter, response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 8'h00;
            r_resp  <= IDLE_RESP;
            r_tcnt  <= '0;
        end else if (w_ssel_s) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_tcnt  <= '0;
            r_resp  <= IDLE_RESP;
        end else begin
            if (r_req) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_addr <= cmd[ADDR_W-1:0];
                        if (cmd[HDR_RW_BIT]) begin
                            r_state <= WR_WAIT;
                        end else begin
                            r_req   <= 1'b1;
                            r_we    <= 1'b0;
                            r_tcnt  <= '0;
                            r_state <= RD_BUS;
                        end
                    end
                end
                WR_WAIT: begin
                    if (cmd_valid) begin
                        r_wdata <= cmd;
                        r_req   <= 1'b1;
                        r_we    <= 1'b1;
                        r_tcnt  <= '0;
                        r_state <= WR_BUS;
                    end
                end
                WR_BUS: begin
                    if (w_done || w_tout) begin
                        r_req   <= 1'b0;
                        r_addr  <= r_addr + 1'b1;
                        r_state <= WR_WAIT;
                    end
                end
                RD_BUS: begin
                    if (w_done) begin
                        r_resp  <= bus.bus_rdata;
                        r_req   <= 1'b0;
                        r_addr  <= r_addr + 1'b1;
                        r_state <= RD_WAIT;
                    end else if (w_tout) begin
                        r_resp  <= RESP_TIMEOUT;
                        r_req   <= 1'b0;
                        r_addr  <= r_addr + 1'b1;
                        r_state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // The byte just shifted carried the data; prefetch the next address
                    if (cmd_valid) begin
                        r_req   <= 1'b1;
                        r_we    <= 1'b0;
                        r_tcnt  <= '0;
                        r_state <= RD_BUS;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_to <= 1'b0;
            r_err_ov <= 1'b0;
        end else begin
            if (w_tout) begin
                r_err_to <= 1'b1;
            end else if (err_clr) begin
                r_err_to <= 1'b0;
            end
            if (w_ovr) begin
                r_err_ov <= 1'b1;
            end else if (err_clr) begin
                r_err_ov <= 1'b0;
            end
        end
    end

    assign bus.bus_req   = r_req;
    assign bus.bus_we    = r_we;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_wdata = r_wdata;
    assign response      = r_resp;
    assign err_timeout   = r_err_to;
    assign err_overrun   = r_err_ov;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: byte-level SPI stimulus, a 128x8 register model
// on the bus, directed table vectors, corner sequences and random frames.
module tb_spi_reg_ctrl;
    localparam int         AW     = 7;
    localparam int         TO     = 15;
    localparam int         GAP    = 24;
    localparam logic [7:0] IDLE_R = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ssel;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic [7:0] response;
    logic       err_timeout;
    logic       err_overrun;
    logic       err_clr;

    spi_reg_ctrl_if #(.ADDR_W(AW)) bus ();

    spi_reg_ctrl #(.ADDR_W(AW), .ACK_TIMEOUT(TO), .IDLE_RESP(IDLE_R)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ssel        (ssel),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .response    (response),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .err_clr     (err_clr),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    // ---------------- register model on the bus ----------------
    logic [7:0] mem [128];
    logic       ack_en  = 1'b1;
    int         ack_lat = 2;
    logic       pl_en   = 1'b0;
    logic [6:0] pl_addr = '0;
    logic [7:0] pl_data = '0;
    int         n_pulses = 0;
    int         req_run  = 0;
    int         last_run = 0;
    logic       prev_req = 1'b0;
    logic       acked    = 1'b0;
    logic       we_at_rise = 1'b0;

    always @(negedge clk) begin
        bus.bus_ack = 1'b0;
        if (pl_en) mem[pl_addr] = pl_data;
        if (bus.bus_req) begin
            if (!prev_req) begin
                n_pulses   = n_pulses + 1;
                we_at_rise = bus.bus_we;
                acked      = 1'b0;
                req_run    = 0;
            end
            req_run = req_run + 1;
            if (ack_en && !acked && req_run == ack_lat) begin
                bus.bus_ack = 1'b1;
                acked = 1'b1;
                if (bus.bus_we) mem[bus.bus_addr] = bus.bus_wdata;
                else            bus.bus_rdata     = mem[bus.bus_addr];
            end
        end else if (prev_req) begin
            last_run = req_run;
        end
        prev_req = bus.bus_req;
    end

    // ---------------- reference model and checking ----------------
    logic [7:0] exp_mem [128];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [6:0] a, input logic [7:0] d);
        @(posedge clk);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        exp_mem[a] = d;
        @(posedge clk);
        pl_en = 1'b0;
    endtask

    task automatic frame_begin();
        @(negedge clk);
        ssel = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end();
        ssel = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // One SPI byte: the response present as it starts is what shifts out on MISO
    task automatic send_byte(input logic [7:0] b, output logic [7:0] miso);
        miso = response;
        cmd = b; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    // Reference: a frame is a header {rw,addr} then n bytes; writes land at
    // consecutive addresses mod 128, reads return IDLE_R then mem[addr+k].
    logic [7:0] tx [5];
    logic [7:0] rx [5];
    logic [7:0] ex [5];

    task automatic model_frame(input int n);
        logic [6:0] a;
        a = tx[0][6:0];
        ex[0] = IDLE_R;
        for (int k = 1; k <= n; k++) begin
            if (tx[0][7]) begin
                ex[k] = IDLE_R;
                exp_mem[7'(a + k - 1)] = tx[k];
            end else begin
                ex[k] = exp_mem[7'(a + k - 1)];
            end
        end
    endtask

    task automatic run_frame(input int n);
        frame_begin();
        for (int k = 0; k <= n; k++) send_byte(tx[k], rx[k]);
        frame_end();
    endtask

    typedef struct {
        logic [7:0] hdr, b1, b2;
        logic [7:0] m0, m1, m2;
        int         pulses;
        logic       we;
        logic [6:0] a0, a1;
        logic [7:0] d0, d1;
    } vec_t;

    vec_t vt [3];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m;
        int p0, k, len;
        logic mem_ok;

        vt[0] = '{hdr:8'h85, b1:8'h11, b2:8'h22, m0:8'hA5, m1:8'hA5, m2:8'hA5,
                  pulses:2, we:1'b1, a0:7'h05, a1:7'h06, d0:8'h11, d1:8'h22};
        vt[1] = '{hdr:8'h03, b1:8'h00, b2:8'h00, m0:8'hA5, m1:8'h5A, m2:8'hC3,
                  pulses:3, we:1'b0, a0:7'h03, a1:7'h04, d0:8'h5A, d1:8'hC3};
        vt[2] = '{hdr:8'hFF, b1:8'h01, b2:8'h02, m0:8'hA5, m1:8'hA5, m2:8'hA5,
                  pulses:2, we:1'b1, a0:7'h7F, a1:7'h00, d0:8'h01, d1:8'h02};

        rst_n = 1'b0; ssel = 1'b1; cmd = 8'h00; cmd_valid = 1'b0; err_clr = 1'b0;
        bus.bus_rdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_response", response, IDLE_R);
        chk("reset_bus_req", bus.bus_req, 0);
        chk("reset_bus_we", bus.bus_we, 0);
        chk("reset_bus_addr", bus.bus_addr, 0);
        chk("reset_bus_wdata", bus.bus_wdata, 0);
        chk("reset_errs", {err_timeout, err_overrun}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 128; i++) preload(7'(i), 8'($urandom));
        preload(7'h03, 8'h5A);
        preload(7'h04, 8'hC3);

        // Directed table
        for (int i = 0; i < 3; i++) begin
            tx[0] = vt[i].hdr; tx[1] = vt[i].b1; tx[2] = vt[i].b2;
            model_frame(2);
            p0 = n_pulses;
            run_frame(2);
            chk($sformatf("tbl%0d_miso0", i), rx[0], vt[i].m0);
            chk($sformatf("tbl%0d_miso1", i), rx[1], vt[i].m1);
            chk($sformatf("tbl%0d_miso2", i), rx[2], vt[i].m2);
            chk($sformatf("tbl%0d_pulses", i), n_pulses - p0, vt[i].pulses);
            chk($sformatf("tbl%0d_we", i), we_at_rise, vt[i].we);
            chk($sformatf("tbl%0d_reg_a0", i), mem[vt[i].a0], vt[i].d0);
            chk($sformatf("tbl%0d_reg_a1", i), mem[vt[i].a1], vt[i].d1);
        end

        // Timeout: no ack on a read
        ack_en = 1'b0;
        frame_begin();
        send_byte(8'h10, m);
        chk("to_miso_hdr", m, IDLE_R);
        chk("to_req_cycles", last_run, TO);
        chk("to_err_timeout", err_timeout, 1);
        send_byte(8'h00, m);
        chk("to_miso_ff", m, 8'hFF);
        frame_end();
        ack_en = 1'b1;
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        chk("to_err_cleared", err_timeout, 0);

        // Abort during WR_BUS
        ack_en = 1'b0;
        frame_begin();
        send_byte(8'hC0, m);
        cmd = 8'h77; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort_req_up", bus.bus_req, 1);
        ssel = 1'b1;
        k = 0;
        while (bus.bus_req && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("abort_req_dropped", bus.bus_req, 0);
        chk("abort_latency_le3", (k <= 3), 1);
        repeat (4) @(negedge clk);
        chk("abort_response", response, IDLE_R);
        chk("abort_no_timeout", err_timeout, 0);
        chk("abort_no_write", mem[7'h40], exp_mem[7'h40]);
        ack_en = 1'b1;
        tx[0] = 8'h82; tx[1] = 8'h33;
        model_frame(1);
        run_frame(1);
        chk("abort_next_reg2", mem[7'h02], 8'h33);

        // Overrun during RD_BUS, set-wins, then clear
        ack_en = 1'b0;
        frame_begin();
        cmd = 8'h20; cmd_valid = 1'b1; @(negedge clk);
        cmd_valid = 1'b0; @(negedge clk);
        cmd = 8'h55; cmd_valid = 1'b1; @(negedge clk);
        chk("ovr_set", err_overrun, 1);
        err_clr = 1'b1; @(negedge clk);
        chk("ovr_set_wins", err_overrun, 1);
        cmd_valid = 1'b0; @(negedge clk);
        err_clr = 1'b0;
        chk("ovr_cleared", err_overrun, 0);
        repeat (GAP) @(negedge clk);
        frame_end();
        ack_en = 1'b1;
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;

        // Reset mid-frame
        frame_begin();
        send_byte(8'h90, m);
        cmd = 8'h44; cmd_valid = 1'b1; @(negedge clk);
        cmd_valid = 1'b0;
        cmd_valid = 1'b1; @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst_pre_overrun", err_overrun, 1);
        rst_n = 1'b0; #1;
        chk("rst_mid_req", bus.bus_req, 0);
        chk("rst_mid_we", bus.bus_we, 0);
        chk("rst_mid_addr", bus.bus_addr, 0);
        chk("rst_mid_wdata", bus.bus_wdata, 0);
        chk("rst_mid_resp", response, IDLE_R);
        chk("rst_mid_errs", {err_timeout, err_overrun}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ssel = 1'b1;
        repeat (GAP) @(negedge clk);
        // The ack for reg 0x10 may have landed before reset; resync the model
        exp_mem[7'h10] = mem[7'h10];

        // Random frames against the reference model
        for (int f = 0; f < 20; f++) begin
            ack_lat = $urandom_range(1, 4);
            len = $urandom_range(1, 4);
            tx[0] = 8'($urandom);
            for (int j = 1; j <= len; j++) tx[j] = 8'($urandom);
            model_frame(len);
            run_frame(len);
            if (!tx[0][7]) begin
                for (int j = 0; j <= len; j++)
                    chk($sformatf("rnd%0d_rd_miso%0d", f, j), rx[j], ex[j]);
            end else begin
                mem_ok = 1'b1;
                for (int j = 0; j < 128; j++) if (mem[j] !== exp_mem[j]) mem_ok = 1'b0;
                chk($sformatf("rnd%0d_wr_mem", f), mem_ok, 1);
            end
        end
        chk("rnd_no_errs", {err_timeout, err_overrun}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
